// File: rtl/ro_freq_counter.sv
// ro_freq_counter
//
// This block measures the frequency of a ring oscillator. It counts rising
// edges of ro_in over a gate window of programmable length, measured in clk
// cycles. A measurement runs in three phases:
//   1. The oscillator is enabled for SETTLE_CYCLES so that it can stabilise.
//   2. Edges are counted for window_len cycles.
//   3. A one-cycle done pulse marks count and overflow as valid.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle measurement request, honoured only while idle
//   window_len  gate window length in clk cycles, latched when start is taken
//   ro_in       ring-oscillator output, asynchronous to clk
//   ro_en       oscillator enable (registered), high in SETTLE and COUNT
//   busy        high while a measurement is in progress
//   done        one-cycle pulse when count/overflow are valid
//   count       rising edges seen in the window, saturating at all-ones
//   overflow    set when an increment was attempted at all-ones
module ro_freq_counter #(
    parameter int CNT_W         = 16,
    parameter int WIN_W         = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [7:0]         settle_cnt_reg, settle_cnt_next;
    logic [WIN_W-1:0]   win_left_reg, win_left_next;
    logic               clear_meas;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic               prev_reg;
    logic               rise;

    logic               ro_en_reg, busy_reg, done_reg, overflow_reg;
    logic [CNT_W-1:0]   count_reg;

    // ro_in synchronizer followed by a previous-value register. Both load in
    // every state, so the edge detector already holds history when COUNT
    // begins. A level that is steady on entry therefore cannot be mistaken
    // for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro_in};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    // State and phase counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= '0;
            win_left_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            win_left_reg   <= win_left_next;
        end
    end

    // win_left_reg holds the number of COUNT cycles still to run, including
    // the current one. COUNT therefore exits when it reaches 1.
    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        win_left_next   = win_left_reg;
        clear_meas      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    clear_meas      = 1'b1;
                    win_left_next   = window_len;
                    settle_cnt_next = '0;
                    state_next      = (window_len == '0) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next = ST_COUNT;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 8'd1;
                end
            end
            ST_COUNT: begin
                win_left_next = win_left_reg - 1'b1;
                if (win_left_reg == WIN_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state and then registered, so
    // they line up with the state register without any combinational glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            ro_en_reg <= (state_next == ST_SETTLE) || (state_next == ST_COUNT);
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    // Edge counter. It saturates at all-ones and flags overflow. The result
    // is held until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear_meas) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if ((state_reg == ST_COUNT) && rise) begin
            if (&count_reg) begin
                overflow_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign ro_en    = ro_en_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule
